grade_sort_sequencer: RTL and testbench



---
 rtl/grade_sort_sequencer.sv | 157 +++++++++++++++
 tb/tb_grade_sort_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grade_sort_sequencer.sv
// Conveyor grading sequencer: accepts one item, waits for the sensors to settle, grades it,
// holds the diverter gate on the matching bin, and keeps saturating per-grade tallies.
module grade_sort_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned GATE_CYCLES   = 8,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             item_valid_i,
  output logic             item_ready_o,
  input  logic             weight_ok_i,
  input  logic             size_ok_i,
  input  logic             color_ok_i,
  input  logic             clear_counts_i,
  output logic             grade_valid_o,
  output logic [1:0]       grade_o,
  output logic [1:0]       bin_sel_o,
  output logic             gate_en_o,
  output logic [CNT_W-1:0] cnt_high_o,
  output logic [CNT_W-1:0] cnt_medium_o,
  output logic [CNT_W-1:0] cnt_low_o,
  output logic [CNT_W-1:0] cnt_reject_o,
  output logic             overrun_o
);

  localparam int unsigned MaxCycles = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES
                                                                     : GATE_CYCLES;
  localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [TimerW-1:0] SettleLoad = TimerW'(SETTLE_CYCLES - 1);
  localparam logic [TimerW-1:0] GateLoad   = TimerW'(GATE_CYCLES - 1);

  localparam logic [1:0] GradeHigh   = 2'd3;
  localparam logic [1:0] GradeMedium = 2'd2;
  localparam logic [1:0] GradeLow    = 2'd1;
  localparam logic [1:0] GradeReject = 2'd0;

  typedef enum logic [1:0] {StIdle, StSettle, StGrade, StDivert} state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [1:0]          grade_q, grade_d;
  logic [1:0]          bin_sel_q;
  logic                sample;
  logic                valid_q;
  logic                overrun_q;
  logic [CNT_W-1:0]    cnt_q [4];

  always_comb begin
    if (!weight_ok_i) begin
      grade_d = GradeReject;
    end else if (!size_ok_i) begin
      grade_d = GradeLow;
    end else if (!color_ok_i) begin
      grade_d = GradeMedium;
    end else begin
      grade_d = GradeHigh;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    sample  = 1'b0;
    case (state_q)
      StIdle: begin
        if (item_valid_i) begin
          state_d = StSettle;
          timer_d = SettleLoad;
        end
      end
      StSettle: begin
        if (timer_q == '0) begin
          state_d = StGrade;
          sample  = 1'b1;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StGrade: begin
        state_d = StDivert;
        timer_d = GateLoad;
      end
      StDivert: begin
        if (timer_q == '0) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      grade_q   <= GradeReject;
      bin_sel_q <= GradeReject;
      valid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      valid_q <= item_valid_i;
      if (sample) begin
        grade_q <= grade_d;
      end
      if (state_q == StGrade) begin
        bin_sel_q <= grade_q;
      end
    end
  end

  // Only a fresh offer while busy is an overrun; a level held since acceptance is the
  // pending next item, picked up in the following idle cycle.
  logic overrun_set;
  assign overrun_set = item_valid_i && !valid_q && (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (clear_counts_i) begin
      overrun_q <= 1'b0;
    end else if (overrun_set) begin
      overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (clear_counts_i) begin
          cnt_q[i] <= '0;
        end else if (state_q == StGrade && grade_q == 2'(i) && cnt_q[i] != '1) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign item_ready_o  = (state_q == StIdle);
  assign grade_valid_o = (state_q == StGrade);
  assign grade_o       = (state_q == StGrade) ? grade_q : 2'd0;
  assign gate_en_o     = (state_q == StDivert);
  assign bin_sel_o     = bin_sel_q;
  assign overrun_o     = overrun_q;
  assign cnt_high_o    = cnt_q[3];
  assign cnt_medium_o  = cnt_q[2];
  assign cnt_low_o     = cnt_q[1];
  assign cnt_reject_o  = cnt_q[0];

endmodule

// File: tb/tb_grade_sort_sequencer.sv
// Directed bench for grade_sort_sequencer: a default instance plus a CNT_W=2 instance
// sharing the same stimulus for the saturation cases.
module tb_grade_sort_sequencer;

  localparam int S = 4;
  localparam int G = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic item_valid, w, s, c, clr;

  logic       ready, gv, gate, ovr;
  logic [1:0] gr, bin;
  logic [7:0] ch, cm, cl, cr;
  logic       ready2, gv2, gate2, ovr2;
  logic [1:0] gr2, bin2;
  logic [1:0] ch2, cm2, cl2, cr2;

  int errors = 0;
  int checks = 0;
  int exp_cnt [4];
  int exp_cnt2 [4];

  typedef struct {
    logic w;
    logic s;
    logic c;
    int   grade;
  } vec_t;

  always #5 clk = ~clk;

  grade_sort_sequencer dut (
    .clk(clk), .rst_n(rst_n), .item_valid_i(item_valid), .item_ready_o(ready),
    .weight_ok_i(w), .size_ok_i(s), .color_ok_i(c), .clear_counts_i(clr),
    .grade_valid_o(gv), .grade_o(gr), .bin_sel_o(bin), .gate_en_o(gate),
    .cnt_high_o(ch), .cnt_medium_o(cm), .cnt_low_o(cl), .cnt_reject_o(cr),
    .overrun_o(ovr)
  );

  grade_sort_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .item_valid_i(item_valid), .item_ready_o(ready2),
    .weight_ok_i(w), .size_ok_i(s), .color_ok_i(c), .clear_counts_i(clr),
    .grade_valid_o(gv2), .grade_o(gr2), .bin_sel_o(bin2), .gate_en_o(gate2),
    .cnt_high_o(ch2), .cnt_medium_o(cm2), .cnt_low_o(cl2), .cnt_reject_o(cr2),
    .overrun_o(ovr2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic bump(input int g);
    if (exp_cnt[g] < 255) exp_cnt[g]++;
    if (exp_cnt2[g] < 3) exp_cnt2[g]++;
  endtask

  task automatic zero_model();
    for (int i = 0; i < 4; i++) begin
      exp_cnt[i]  = 0;
      exp_cnt2[i] = 0;
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_cnt_high"},    32'(ch),  exp_cnt[3]);
    check({tag, "_cnt_medium"},  32'(cm),  exp_cnt[2]);
    check({tag, "_cnt_low"},     32'(cl),  exp_cnt[1]);
    check({tag, "_cnt_reject"},  32'(cr),  exp_cnt[0]);
    check({tag, "_cnt2_high"},   32'(ch2), exp_cnt2[3]);
    check({tag, "_cnt2_reject"}, 32'(cr2), exp_cnt2[0]);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_wait_ready"}, 32'(ready), 1);
  endtask

  // Single item with valid pulsed for one cycle; checks the full timeline.
  task automatic run_item(input logic iw, input logic is, input logic ic, input int g);
    int gate_cycles;
    logic bin_ok;
    @(negedge clk);
    check("item_ready_before", 32'(ready), 1);
    item_valid = 1'b1; w = iw; s = is; c = ic;
    @(negedge clk);                            // T0+1
    item_valid = 1'b0;
    check("item_ready_busy", 32'(ready), 0);
    repeat (S - 1) @(negedge clk);             // T0+S
    check("no_early_grade", 32'(gv), 0);
    @(negedge clk);                            // T0+S+1
    check("grade_valid", 32'(gv), 1);
    check("grade", 32'(gr), g);
    gate_cycles = 0;
    bin_ok = 1'b1;
    repeat (G) begin
      @(negedge clk);
      if (gate) gate_cycles++;
      if (bin !== 2'(g)) bin_ok = 1'b0;
    end
    check("gate_cycles", gate_cycles, G);
    check("bin_sel_during_divert", 32'(bin_ok), 1);
    bump(g);
    check_counts("item");
    @(negedge clk);                            // T0+S+G+2
    check("item_ready_after", 32'(ready), 1);
    check("gate_off_after", 32'(gate), 0);
    check("bin_sel_held", 32'(bin), g);
  endtask

  vec_t vecs [6];
  vec_t b2b [4];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 3};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 2};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1};
    b2b[0]  = '{1'b1, 1'b1, 1'b0, 2};
    b2b[1]  = '{1'b1, 1'b0, 1'b1, 1};
    b2b[2]  = '{1'b0, 1'b1, 1'b1, 0};
    b2b[3]  = '{1'b1, 1'b1, 1'b1, 3};

    zero_model();
    rst_n = 1'b0; item_valid = 1'b0; w = 1'b0; s = 1'b0; c = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_item_ready", 32'(ready), 1);
    check("rst_grade_valid", 32'(gv), 0);
    check("rst_grade", 32'(gr), 0);
    check("rst_bin_sel", 32'(bin), 0);
    check("rst_gate_en", 32'(gate), 0);
    check("rst_overrun", 32'(ovr), 0);
    check_counts("rst");
    rst_n = 1'b1;

    // Table of single items
    for (int i = 0; i < 6; i++) begin
      run_item(vecs[i].w, vecs[i].s, vecs[i].c, vecs[i].grade);
    end

    // Back-to-back items with item_valid held high
    begin
      int last;
      int n;
      @(negedge clk);
      w = b2b[0].w; s = b2b[0].s; c = b2b[0].c;
      item_valid = 1'b1;
      last = 0;
      for (int k = 0; k < 4; k++) begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!gv && n < 40);
        check("b2b_grade_seen", 32'(gv), 1);
        check("b2b_grade", 32'(gr), b2b[k].grade);
        if (k > 0) check("b2b_spacing", cyc - last, S + G + 2);
        last = cyc;
        bump(b2b[k].grade);
        if (k < 3) begin
          w = b2b[k + 1].w; s = b2b[k + 1].s; c = b2b[k + 1].c;
        end else begin
          item_valid = 1'b0;
        end
      end
      wait_ready("b2b");
      check("b2b_overrun", 32'(ovr), 0);
      check_counts("b2b");
    end

    // Sensors change two cycles before the sampling edge
    @(negedge clk);
    item_valid = 1'b1; w = 1'b1; s = 1'b1; c = 1'b1;
    @(negedge clk);                            // T0+1
    item_valid = 1'b0;
    @(negedge clk);                            // T0+2
    @(negedge clk);                            // T0+3
    w = 1'b1; s = 1'b0; c = 1'b0;
    @(negedge clk);                            // T0+4
    @(negedge clk);                            // T0+5
    check("midsettle_grade_valid", 32'(gv), 1);
    check("midsettle_grade", 32'(gr), 1);
    bump(1);
    wait_ready("midsettle");
    check_counts("midsettle");

    // Item offered during DIVERT
    begin
      int extra;
      @(negedge clk);
      item_valid = 1'b1; w = 1'b1; s = 1'b1; c = 1'b1;
      @(negedge clk);                          // T0+1
      item_valid = 1'b0;
      repeat (6) @(negedge clk);               // T0+7, in DIVERT
      check("ovr_in_divert_gate", 32'(gate), 1);
      item_valid = 1'b1;
      @(negedge clk);                          // T0+8
      item_valid = 1'b0;
      check("overrun_set", 32'(ovr), 1);
      extra = 0;
      repeat (25) begin
        @(negedge clk);
        if (gv) extra++;
      end
      check("overrun_no_extra_grade", extra, 0);
      check("overrun_sticky", 32'(ovr), 1);
      bump(3);
      check_counts("overrun");
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clear_overrun", 32'(ovr), 0);
      zero_model();
      check_counts("clear");
    end

    // Saturation of the narrow instance
    for (int i = 0; i < 5; i++) begin
      run_item(1'b0, 1'b0, 1'b0, 0);
    end
    check("sat_cnt2_reject", 32'(cr2), 3);
    check("sat_cnt_reject", 32'(cr), 5);

    // Clear in the same cycle as GRADE wins over the increment
    @(negedge clk);
    item_valid = 1'b1; w = 1'b0; s = 1'b0; c = 1'b0;
    @(negedge clk);                            // T0+1
    item_valid = 1'b0;
    repeat (S) @(negedge clk);                 // T0+S+1, GRADE
    check("clr_grade_cycle", 32'(gv), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_vs_inc_cnt_reject", 32'(cr), 0);
    check("clr_vs_inc_cnt2_reject", 32'(cr2), 0);
    zero_model();
    wait_ready("clr_grade");
    check_counts("clr_grade");

    // Reset in the middle of DIVERT
    @(negedge clk);
    item_valid = 1'b1; w = 1'b1; s = 1'b1; c = 1'b1;
    @(negedge clk);                            // T0+1
    item_valid = 1'b0;
    repeat (7) @(negedge clk);                 // T0+8
    check("pre_reset_gate", 32'(gate), 1);
    rst_n = 1'b0;
    #1;
    check("reset_gate_off", 32'(gate), 0);
    check("reset_ready", 32'(ready), 1);
    zero_model();
    check_counts("reset_abort");
    @(negedge clk);
    rst_n = 1'b1;
    run_item(1'b1, 1'b1, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
